// File: rtl/inv_shift_rows_stage.sv
// Registered AES InvShiftRows stage: permutes each accepted state, tags it with a
// per-block round number and sbox seed, and buffers it in a small circular FIFO.
module inv_shift_rows_stage #(
  parameter int ROUND_START = 13,
  parameter int DEPTH       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [127:0] in_state,
  input  logic [255:0] in_seed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [255:0] out_seed,
  output logic [31:0]  out_round_num,
  output logic         out_last,
  output logic         err_seq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [127:0] perm_state;

  // out[r][c] = in[r][(c - r) mod 4]; byte i sits at row i%4, column i/4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_perm
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    assign perm_state[127-8*gi -: 8] = in_state[127-8*SRC -: 8];
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rnd_q, rnd_d;
  logic             in_block_q, in_block_d;
  logic             err_seq_q, err_seq_d;

  logic [127:0] mem_state [DEPTH];
  logic [255:0] mem_seed  [DEPTH];
  logic [4:0]   mem_tag   [DEPTH];
  logic         mem_last  [DEPTH];

  logic       accept;
  logic       release_beat;
  logic [4:0] tag;

  assign in_ready     = (count_q < CNT_W'(DEPTH));
  assign out_valid    = (count_q != '0);
  assign accept       = in_valid && in_ready;
  assign release_beat = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rnd_d      = rnd_q;
    in_block_d = in_block_q;
    err_seq_d  = err_seq_q;
    tag        = '0;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (in_first) begin
        tag        = 5'(ROUND_START);
        rnd_d      = 5'(ROUND_START - 1);
        in_block_d = 1'b1;
        if (in_block_q && (rnd_q != '0)) err_seq_d = 1'b1;
      end else if (in_block_q) begin
        tag = rnd_q;
        if (rnd_q == '0) in_block_d = 1'b0;
        else             rnd_d      = rnd_q - 5'd1;
      end else begin
        // Orphan beat: still stored so the data stream is never dropped.
        err_seq_d = 1'b1;
      end
    end

    if (release_beat) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (accept && !release_beat)      count_d = count_q + CNT_W'(1);
    else if (!accept && release_beat) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rnd_q      <= '0;
      in_block_q <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rnd_q      <= rnd_d;
      in_block_q <= in_block_d;
      err_seq_q  <= err_seq_d;
    end
  end

  // Storage carries no reset; outputs are masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_state[wr_ptr_q] <= perm_state;
      mem_seed[wr_ptr_q]  <= in_seed;
      mem_tag[wr_ptr_q]   <= tag;
      mem_last[wr_ptr_q]  <= (tag == '0);
    end
  end

  assign out_state     = out_valid ? mem_state[rd_ptr_q] : '0;
  assign out_seed      = out_valid ? mem_seed[rd_ptr_q]  : '0;
  assign out_round_num = out_valid ? {27'd0, mem_tag[rd_ptr_q]} : '0;
  assign out_last      = out_valid ? mem_last[rd_ptr_q] : 1'b0;
  assign err_seq       = err_seq_q;

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Directed bench for inv_shift_rows_stage: permutation, tagging, backpressure,
// sequencing errors and asynchronous reset.
module tb_inv_shift_rows_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_first = 1'b0;
  logic [127:0] in_state = '0;
  logic [255:0] in_seed = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic [255:0] out_seed;
  logic [31:0]  out_round_num;
  logic         out_last;
  logic         err_seq;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-derived: bytes 00..0f shifted back by row.
  localparam logic [127:0] IN0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EXP0 = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] IN1  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] EXP1 = 128'hff225588bbee114477aadd00336699cc;

  always #5 clk = ~clk;

  inv_shift_rows_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_state(in_state), .in_seed(in_seed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_seed(out_seed),
    .out_round_num(out_round_num), .out_last(out_last), .err_seq(err_seq)
  );

  // Marking the high nibble of every byte leaves the byte order unchanged,
  // so the expected value is EXP0 with the same marker.
  function automatic logic [127:0] mk_in(input int k);
    logic [3:0] n;
    n = 4'(k);
    return IN0 | {16{n, 4'h0}};
  endfunction

  function automatic logic [127:0] mk_exp(input int k);
    logic [3:0] n;
    n = 4'(k);
    return EXP0 | {16{n, 4'h0}};
  endfunction

  function automatic logic [255:0] mk_seed(input int k);
    logic [3:0] n;
    n = 4'(k);
    return {32{4'hC, n}};
  endfunction

  task automatic drive(input logic v, input logic first, input logic [127:0] st,
                       input logic [255:0] sd);
    in_valid = v;
    in_first = first;
    in_state = st;
    in_seed  = sd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_state !== '0) begin n_bad++; $display("FAIL reset_out_state got %h want 0", out_state); end
    n_cmp++; if (out_round_num !== 32'd0 || out_last !== 1'b0) begin n_bad++; $display("FAIL reset_tag got %0d/%b want 0/0", out_round_num, out_last); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL reset_err_seq got %b want 0", err_seq); end
    $display("test_reset done");
  endtask

  task automatic test_permutation();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, IN0, {32{8'hA5}});
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL perm_valid got %b want 1", out_valid); end
    n_cmp++; if (out_state !== EXP0) begin n_bad++; $display("FAIL perm_state got %h want %h", out_state, EXP0); end
    n_cmp++; if (out_seed !== {32{8'hA5}}) begin n_bad++; $display("FAIL perm_seed got %h want a5..", out_seed); end
    n_cmp++; if (out_round_num !== 32'd13 || out_last !== 1'b0) begin n_bad++; $display("FAIL perm_tag got %0d/%b want 13/0", out_round_num, out_last); end
    $display("test_permutation beat state=%h round=%0d", out_state, out_round_num);
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, IN1, '1);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (out_state !== EXP1) begin n_bad++; $display("FAIL perm2_state got %h want %h", out_state, EXP1); end
    $display("test_permutation beat state=%h", out_state);
  endtask

  task automatic test_full_block();
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 14; b++) begin
      drive(1'b1, b == 0, mk_in(b), mk_seed(b));
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL block_in_ready beat %0d got %b want 1", b, in_ready); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_state !== mk_exp(b) || out_seed !== mk_seed(b)) begin
        n_bad++; $display("FAIL block_data beat %0d got %b/%h want 1/%h", b, out_valid, out_state, mk_exp(b));
      end
      n_cmp++; if (out_round_num !== 32'(13 - b) || out_last !== (b == 13)) begin
        n_bad++; $display("FAIL block_tag beat %0d got %0d/%b want %0d/%b", b, out_round_num, out_last, 13 - b, b == 13);
      end
      $display("test_full_block beat %0d round=%0d last=%b", b, out_round_num, out_last);
    end
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL block_err_seq got %b want 0", err_seq); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, mk_in(0), mk_seed(0));
    @(negedge clk);
    n_cmp++; if (out_state !== mk_exp(0) || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first got %h/%b want %h/1", out_state, in_ready, mk_exp(0)); end
    drive(1'b1, 1'b0, mk_in(1), mk_seed(1));
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || out_state !== mk_exp(0)) begin n_bad++; $display("FAIL bp_full got %b/%h want 0/%h", in_ready, out_state, mk_exp(0)); end
    drive(1'b1, 1'b0, mk_in(2), mk_seed(2));
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || out_state !== mk_exp(0) || out_round_num !== 32'd13 || out_seed !== mk_seed(0)) begin
      n_bad++; $display("FAIL bp_hold got %b/%h/%0d want 0/%h/13", in_ready, out_state, out_round_num, mk_exp(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_state !== mk_exp(1) || out_round_num !== 32'd12 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_drain1 got %h/%0d/%b want %h/12/1", out_state, out_round_num, in_ready, mk_exp(1));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (out_state !== mk_exp(2) || out_round_num !== 32'd11 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_drain2 got %h/%0d/%b want %h/11/1", out_state, out_round_num, out_valid, mk_exp(2));
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", out_valid); end
    $display("test_backpressure drained three beats");
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, mk_in(0), mk_seed(0));
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      drive(1'b1, 1'b0, mk_in(k), mk_seed(k));
      @(negedge clk);
      n_cmp++; if (out_state !== mk_exp(k) || in_ready !== 1'b1 || out_round_num !== 32'(13 - k)) begin
        n_bad++; $display("FAIL b2b beat %0d got %h/%b/%0d want %h/1/%0d", k, out_state, in_ready, out_round_num, mk_exp(k), 13 - k);
      end
      $display("test_back_to_back beat %0d round=%0d", k, out_round_num);
    end
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_seq_errors();
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, b == 0, mk_in(b), mk_seed(b));
      @(negedge clk);
    end
    n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL seq_before got %b want 0", err_seq); end
    drive(1'b1, 1'b1, mk_in(5), mk_seed(5));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (err_seq !== 1'b1 || out_round_num !== 32'd13) begin n_bad++; $display("FAIL seq_trunc got %b/%0d want 1/13", err_seq, out_round_num); end
    $display("test_seq_errors truncated err=%b round=%0d", err_seq, out_round_num);
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, IN1, mk_seed(7));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (err_seq !== 1'b1 || out_round_num !== 32'd0 || out_last !== 1'b1 || out_state !== EXP1) begin
      n_bad++; $display("FAIL seq_orphan got %b/%0d/%b/%h want 1/0/1/%h", err_seq, out_round_num, out_last, out_state, EXP1);
    end
    $display("test_seq_errors orphan err=%b round=%0d last=%b", err_seq, out_round_num, out_last);
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, b == 0, mk_in(b), mk_seed(b));
      @(negedge clk);
    end
    out_ready = 1'b0;
    drive(1'b1, 1'b0, mk_in(5), mk_seed(5));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (in_ready !== 1'b0 || out_round_num !== 32'd9) begin n_bad++; $display("FAIL ar_full got %b/%0d want 0/9", in_ready, out_round_num); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_state !== '0 || out_seed !== '0) begin n_bad++; $display("FAIL ar_immediate got %b/%h want 0/0", out_valid, out_state); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || err_seq !== 1'b0) begin n_bad++; $display("FAIL ar_release got %b/%b want 1/0", in_ready, err_seq); end
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, IN0, mk_seed(3));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++; if (out_round_num !== 32'd13 || err_seq !== 1'b0 || out_state !== EXP0) begin
      n_bad++; $display("FAIL ar_restart got %0d/%b/%h want 13/0/%h", out_round_num, err_seq, out_state, EXP0);
    end
    $display("test_async_reset restart round=%0d err=%b", out_round_num, err_seq);
  endtask

  initial begin
    test_reset();
    test_permutation();
    test_full_block();
    test_backpressure();
    test_back_to_back();
    test_seq_errors();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
